sram_ahb_ctrl: RTL and testbench
================================

Name: sram_ahb_ctrl

Overview:
Parametrised AHB-Lite slave that bridges hclk-domain bus transfers onto a single-port synchronous SRAM. It generalises the fixed 8-bit controller: configurable data width with byte lanes, independent read/write wait states, byte/halfword/word writes, back-to-back pipelined transfers and a two-cycle ERROR response for illegal accesses. It sits between the AHB interconnect and one SRAM macro, and shares the SRAM clock with hclk.

Parameters:
ADDR_WIDTH, 10, byte-address width of haddr; SRAM word address = haddr[ADDR_WIDTH-1:log2(NBYTES)]
WORD_WIDTH, 32, data width in bits; must be 8, 16, 32 or 64; NBYTES = WORD_WIDTH/8
WRITE_WAIT, 1, hready-low cycles inserted in a write data phase (legal range 0..15)
READ_WAIT, 2, hready-low cycles inserted in a read data phase (legal range 1..15; SRAM read latency is 1)

Ports:
hclk  in  1  bus and SRAM clock
hreset  in  1  asynchronous reset, active-high
hsel  in  1  slave select
htrans  in  2  AHB transfer type; only NONSEQ(10) and SEQ(11) start transfers
haddr  in  ADDR_WIDTH  byte address, address phase
hwrite  in  1  1 = write, 0 = read, address phase
hsize  in  3  000 byte, 001 halfword, 010 word, 011 doubleword
hwdata  in  WORD_WIDTH  write data, data phase; held stable while hready is low
hready  out  1  transfer done / slave ready
hresp  out  1  1 = ERROR
hrdata  out  WORD_WIDTH  read data
sram_clk  out  1  equals hclk
sram_cs_n  out  1  chip select, active-low
sram_we_n  out  1  write strobe, active-low
sram_be  out  NBYTES  byte-write enables, active-high
sram_addr  out  ADDR_WIDTH-log2(NBYTES)  word address
sram_din  out  WORD_WIDTH  write data to SRAM
sram_dout  in  WORD_WIDTH  SRAM read data, valid one cycle after the address is presented with cs_n low

Behaviour:
- Reset, asynchronous: state IDLE, cnt=0, hready=1, hresp=0, hrdata=0, sram_cs_n=1, sram_we_n=1, sram_be=0, sram_addr=0. Reset mid-transfer aborts without an SRAM write.
- Accept condition: hsel & htrans[1] & hready at a rising edge. On accept, register addr, hwrite, hsize and the byte-lane mask. Otherwise the block takes no action.
- Illegal access: (8<<hsize) > WORD_WIDTH, or haddr not aligned to the size. The block goes to ERR1 and never touches the SRAM.
- States:
  - IDLE: hready=1, hresp=0.
  - ACCESS: cnt counts from 0 up to N, where N=WRITE_WAIT for writes and N=READ_WAIT for reads. hready = (cnt==N).
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- Transitions:
  - IDLE goes to ACCESS (cnt=0) or ERR1 on accept.
  - ACCESS with cnt<N increments cnt.
  - ACCESS with cnt==N: a new accept goes to ACCESS (cnt=0) or ERR1; otherwise the block returns to IDLE.
  - ERR1 always goes to ERR2.
  - ERR2 behaves like IDLE for accepts.
- Write, all outputs decoded from registered state:
  - sram_cs_n=0 throughout ACCESS.
  - sram_we_n=0 only in the cycle cnt==N.
  - sram_be = lane mask only in that cycle, 0 otherwise.
  - sram_din = hwdata, passed through.
  - The SRAM captures the word on the edge ending the final cycle. Write data phase length is WRITE_WAIT+1 cycles.
- Read:
  - sram_cs_n=0 for the whole ACCESS; sram_we_n=1; sram_be=0.
  - In the cycle cnt==N, hrdata = sram_dout (combinational), and hold register <= sram_dout.
  - In all other cycles, hrdata = hold register.
  - Read data phase length is READ_WAIT+1 cycles.
- Lane mask for a byte-address offset o (the low log2(NBYTES) bits):
  - Byte transfer: bit o set.
  - Halfword transfer: bits o and o+1 set.
  - Full-width transfer: all ones.
  - Reads ignore the mask.
- Back-to-back: an accept in the final cycle overwrites the registered address only at the closing edge. The current transfer's sram_addr is therefore unaffected, and there is zero idle cycle between transfers.
- sram_cs_n returns high in IDLE, ERR1 and ERR2.
- htrans IDLE/BUSY and hsel=0 in any state are ignored.

Test Plan:
- Reset, then a word write to 0x010 with data 0xDEADBEEF (WRITE_WAIT=1) -> hready low 1 cycle. The final cycle shows sram_we_n=0, sram_be=1111, sram_addr=0x004, sram_din=0xDEADBEEF.
- Read of 0x010 (READ_WAIT=2) -> hready low 2 cycles; hrdata=0xDEADBEEF when hready rises; hold register keeps the value afterwards.
- Byte write of 0xAB at 0x013 -> sram_be=1000. A subsequent read returns 0xABADBEEF.
- Halfword at 0x011 (misaligned) -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1). sram_cs_n stays high throughout.
- Back-to-back: write 0x020 followed directly by read 0x020 -> no idle cycle; the read returns the written data; sram_addr switches exactly at the boundary.
- hreset asserted during the write wait cycle -> outputs go to reset values immediately and no sram_we_n pulse occurs. A following read of that address returns the old contents.

Source files
------------

// File: rtl/sram_ahb_ctrl_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the SRAM controller (slave side).
// Widths follow the controller's ADDR_WIDTH/WORD_WIDTH so one instance can be passed straight in.
interface sram_ahb_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  hsel;
    logic [1:0]            htrans;
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [WORD_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hresp;
    logic [WORD_WIDTH-1:0] hrdata;

    modport master (
        output hsel, htrans, haddr, hwrite, hsize, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  hsel, htrans, haddr, hwrite, hsize, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/sram_ahb_ctrl.sv
// AHB-Lite slave driving a single-port synchronous SRAM with byte lanes, separate read/write
// wait states, pipelined back-to-back transfers and a two-cycle ERROR response.
module sram_ahb_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned WRITE_WAIT = 1,
    parameter int unsigned READ_WAIT  = 2
) (
    input  logic                                        hclk,
    input  logic                                        hreset,
    sram_ahb_ctrl_if.slave                              ahb,
    output logic                                        sram_clk,
    output logic                                        sram_cs_n,
    output logic                                        sram_we_n,
    output logic [WORD_WIDTH/8-1:0]                     sram_be,
    output logic [ADDR_WIDTH-$clog2(WORD_WIDTH/8)-1:0]  sram_addr,
    output logic [WORD_WIDTH-1:0]                       sram_din,
    input  logic [WORD_WIDTH-1:0]                       sram_dout
);
    localparam int unsigned NBYTES  = WORD_WIDTH / 8;
    localparam int unsigned BYTE_W  = $clog2(NBYTES);
    localparam int unsigned SRAM_AW = ADDR_WIDTH - BYTE_W;
    localparam logic [3:0]  WR_LAST = 4'(WRITE_WAIT);
    localparam logic [3:0]  RD_LAST = 4'(READ_WAIT);

    typedef enum logic [1:0] {StIdle, StAccess, StErr1, StErr2} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [SRAM_AW-1:0]   addr_q;
    logic                 write_q;
    logic [NBYTES-1:0]    mask_q, mask_d;
    logic [WORD_WIDTH-1:0] hold_q;

    logic                  ready, resp;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  accept, illegal, last, rd_capture;

    // Address-phase decode: legality and byte-lane mask from size and low address bits.
    always_comb begin
        int unsigned size_bytes;
        int unsigned offset;
        size_bytes = 32'd1 << ahb.hsize;
        offset     = 32'(ahb.haddr) & (NBYTES - 1);
        illegal    = ((32'd8 << ahb.hsize) > WORD_WIDTH) || ((offset & (size_bytes - 1)) != 0);
        mask_d     = NBYTES'(((64'd1 << size_bytes) - 64'd1) << offset);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready      = 1'b1;
        resp       = 1'b0;
        rdata      = hold_q;
        sram_cs_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be    = '0;
        rd_capture = 1'b0;
        last       = (cnt_q == (write_q ? WR_LAST : RD_LAST));

        unique case (state_q)
            StAccess: begin
                sram_cs_n = 1'b0;
                ready     = last;
                if (write_q) begin
                    sram_we_n = !last;
                    sram_be   = last ? mask_q : '0;
                end else if (last) begin
                    // SRAM output is valid exactly now; forward it and keep a copy.
                    rdata      = sram_dout;
                    rd_capture = 1'b1;
                end
            end
            StErr1: begin
                ready = 1'b0;
                resp  = 1'b1;
            end
            StErr2: begin
                resp = 1'b1;
            end
            default: ;
        endcase

        accept = ahb.hsel && ahb.htrans[1] && ready;

        if (state_q == StErr1) begin
            state_d = StErr2;
        end else if (state_q == StAccess && !last) begin
            cnt_d = cnt_q + 4'd1;
        end else if (accept) begin
            state_d = illegal ? StErr1 : StAccess;
            cnt_d   = '0;
        end else begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loading only at the closing edge keeps sram_addr stable for the transfer in flight.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
        end else if (accept) begin
            addr_q  <= ahb.haddr[ADDR_WIDTH-1:BYTE_W];
            write_q <= ahb.hwrite;
            mask_q  <= mask_d;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            hold_q <= '0;
        end else if (rd_capture) begin
            hold_q <= sram_dout;
        end
    end

    assign ahb.hready = ready;
    assign ahb.hresp  = resp;
    assign ahb.hrdata = rdata;
    assign sram_clk   = hclk;
    assign sram_addr  = addr_q;
    assign sram_din   = ahb.hwdata;
endmodule

// File: tb/tb_sram_ahb_ctrl.sv
// Directed bench for sram_ahb_ctrl: word/byte/halfword writes, reads, errors, pipelining
// and reset abort, against a behavioural byte-lane SRAM.
module tb_sram_ahb_ctrl;
    localparam int unsigned AW = 10;
    localparam int unsigned WW = 32;

    logic        hclk = 1'b0;
    logic        hreset = 1'b0;
    logic        sram_clk, sram_cs_n, sram_we_n;
    logic [3:0]  sram_be;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;
    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;
    int pulses_before = 0;

    sram_ahb_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) ahb ();

    sram_ahb_ctrl #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WRITE_WAIT(1), .READ_WAIT(2)
    ) dut (
        .hclk(hclk), .hreset(hreset), .ahb(ahb), .sram_clk(sram_clk),
        .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 hclk = ~hclk;

    always @(posedge sram_clk) begin
        if (!sram_cs_n) begin
            if (!sram_we_n) begin
                we_pulses <= we_pulses + 1;
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic start_xfer(input logic [9:0] addr, input logic wr, input logic [2:0] size);
        ahb.hsel   = 1'b1;
        ahb.htrans = 2'b10;
        ahb.haddr  = addr;
        ahb.hwrite = wr;
        ahb.hsize  = size;
    endtask

    task automatic idle_bus;
        ahb.hsel   = 1'b0;
        ahb.htrans = 2'b00;
    endtask

    task automatic test_reset;
        idle_bus();
        ahb.haddr = '0; ahb.hwrite = 1'b0; ahb.hsize = 3'd0; ahb.hwdata = '0;
        #1 hreset = 1'b1;
        #1;
        checks++; if (ahb.hready !== 1'b1) begin errors++; $display("FAIL rst_hready: got %0h want 1", ahb.hready); end
        checks++; if (ahb.hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp: got %0h want 0", ahb.hresp); end
        checks++; if (ahb.hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h want 0", ahb.hrdata); end
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %0h want 1", sram_cs_n); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n: got %0h want 1", sram_we_n); end
        checks++; if (sram_be !== 4'h0) begin errors++; $display("FAIL rst_be: got %h want 0", sram_be); end
        checks++; if (sram_addr !== 8'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
        tick();
        tick();
        hreset = 1'b0;
    endtask

    task automatic test_word_write;
        start_xfer(10'h010, 1'b1, 3'd2);
        checks++; if (ahb.hready !== 1'b1) begin errors++; $display("FAIL ww_idle_hready: got %0h want 1", ahb.hready); end
        tick();
        ahb.hwdata = 32'hDEADBEEF;
        idle_bus();
        checks++; if (ahb.hready !== 1'b0) begin errors++; $display("FAIL ww_wait_hready: got %0h want 0", ahb.hready); end
        checks++; if (sram_cs_n !== 1'b0) begin errors++; $display("FAIL ww_wait_cs_n: got %0h want 0", sram_cs_n); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL ww_wait_we_n: got %0h want 1", sram_we_n); end
        checks++; if (sram_be !== 4'h0) begin errors++; $display("FAIL ww_wait_be: got %h want 0", sram_be); end
        tick();
        checks++; if (ahb.hready !== 1'b1) begin errors++; $display("FAIL ww_last_hready: got %0h want 1", ahb.hready); end
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL ww_last_we_n: got %0h want 0", sram_we_n); end
        checks++; if (sram_be !== 4'hF) begin errors++; $display("FAIL ww_last_be: got %h want f", sram_be); end
        checks++; if (sram_addr !== 8'h04) begin errors++; $display("FAIL ww_last_addr: got %h want 04", sram_addr); end
        checks++; if (sram_din !== 32'hDEADBEEF) begin errors++; $display("FAIL ww_last_din: got %h want deadbeef", sram_din); end
        tick();
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL ww_done_cs_n: got %0h want 1", sram_cs_n); end
        checks++; if (we_pulses !== 1) begin errors++; $display("FAIL ww_pulses: got %0d want 1", we_pulses); end
    endtask

    task automatic test_read;
        start_xfer(10'h010, 1'b0, 3'd2);
        tick();
        idle_bus();
        checks++; if (ahb.hready !== 1'b0) begin errors++; $display("FAIL rd_wait0_hready: got %0h want 0", ahb.hready); end
        tick();
        checks++; if (ahb.hready !== 1'b0) begin errors++; $display("FAIL rd_wait1_hready: got %0h want 0", ahb.hready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rd_we_n: got %0h want 1", sram_we_n); end
        tick();
        checks++; if (ahb.hready !== 1'b1) begin errors++; $display("FAIL rd_last_hready: got %0h want 1", ahb.hready); end
        checks++; if (ahb.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_last_data: got %h want deadbeef", ahb.hrdata); end
        checks++; if (ahb.hresp !== 1'b0) begin errors++; $display("FAIL rd_hresp: got %0h want 0", ahb.hresp); end
        tick();
        checks++; if (ahb.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold_data: got %h want deadbeef", ahb.hrdata); end
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL rd_done_cs_n: got %0h want 1", sram_cs_n); end
    endtask

    task automatic test_byte_lanes;
        start_xfer(10'h013, 1'b1, 3'd0);
        tick();
        ahb.hwdata = 32'hAB112233;
        idle_bus();
        tick();
        checks++; if (sram_be !== 4'b1000) begin errors++; $display("FAIL byte_be: got %b want 1000", sram_be); end
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL byte_we_n: got %0h want 0", sram_we_n); end
        tick();
        start_xfer(10'h016, 1'b1, 3'd1);
        tick();
        ahb.hwdata = 32'h55667788;
        idle_bus();
        tick();
        checks++; if (sram_be !== 4'b1100) begin errors++; $display("FAIL half_be: got %b want 1100", sram_be); end
        checks++; if (sram_addr !== 8'h05) begin errors++; $display("FAIL half_addr: got %h want 05", sram_addr); end
        tick();
        start_xfer(10'h010, 1'b0, 3'd2);
        tick();
        idle_bus();
        tick();
        tick();
        checks++; if (ahb.hrdata !== 32'hABADBEEF) begin errors++; $display("FAIL byte_readback: got %h want abadbeef", ahb.hrdata); end
        tick();
    endtask

    task automatic test_error;
        start_xfer(10'h011, 1'b1, 3'd1);
        tick();
        idle_bus();
        checks++; if (ahb.hready !== 1'b0) begin errors++; $display("FAIL err1_hready: got %0h want 0", ahb.hready); end
        checks++; if (ahb.hresp !== 1'b1) begin errors++; $display("FAIL err1_hresp: got %0h want 1", ahb.hresp); end
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL err1_cs_n: got %0h want 1", sram_cs_n); end
        tick();
        checks++; if (ahb.hready !== 1'b1) begin errors++; $display("FAIL err2_hready: got %0h want 1", ahb.hready); end
        checks++; if (ahb.hresp !== 1'b1) begin errors++; $display("FAIL err2_hresp: got %0h want 1", ahb.hresp); end
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL err2_cs_n: got %0h want 1", sram_cs_n); end
        // Doubleword on a 32-bit bus, issued straight out of ERR2.
        start_xfer(10'h018, 1'b0, 3'd3);
        tick();
        idle_bus();
        checks++; if (ahb.hresp !== 1'b1 || ahb.hready !== 1'b0) begin
            errors++; $display("FAIL dw_err1: got resp=%0h ready=%0h want resp=1 ready=0", ahb.hresp, ahb.hready);
        end
        tick();
        start_xfer(10'h010, 1'b0, 3'd2);
        tick();
        idle_bus();
        checks++; if (ahb.hresp !== 1'b0) begin errors++; $display("FAIL err_recover_hresp: got %0h want 0", ahb.hresp); end
        checks++; if (sram_cs_n !== 1'b0) begin errors++; $display("FAIL err_recover_cs_n: got %0h want 0", sram_cs_n); end
        tick();
        tick();
        checks++; if (ahb.hrdata !== 32'hABADBEEF) begin errors++; $display("FAIL err_recover_data: got %h want abadbeef", ahb.hrdata); end
        tick();
        checks++; if (we_pulses !== 3) begin errors++; $display("FAIL err_pulses: got %0d want 3", we_pulses); end
    endtask

    task automatic test_ignored;
        ahb.hsel = 1'b0; ahb.htrans = 2'b10; ahb.haddr = 10'h010; ahb.hwrite = 1'b0;
        tick();
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL nosel_cs_n: got %0h want 1", sram_cs_n); end
        ahb.hsel = 1'b1; ahb.htrans = 2'b01;
        tick();
        checks++; if (sram_cs_n !== 1'b1) begin errors++; $display("FAIL busy_cs_n: got %0h want 1", sram_cs_n); end
        idle_bus();
        tick();
    endtask

    task automatic test_back_to_back;
        start_xfer(10'h020, 1'b1, 3'd2);
        tick();
        ahb.hwdata = 32'h12345678;
        idle_bus();
        checks++; if (sram_addr !== 8'h08) begin errors++; $display("FAIL b2b_w_addr: got %h want 08", sram_addr); end
        tick();
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL b2b_w_we_n: got %0h want 0", sram_we_n); end
        start_xfer(10'h020, 1'b0, 3'd2);
        tick();
        idle_bus();
        checks++; if (sram_cs_n !== 1'b0 || sram_we_n !== 1'b1) begin
            errors++; $display("FAIL b2b_r_start: got cs_n=%0h we_n=%0h want 0/1", sram_cs_n, sram_we_n);
        end
        checks++; if (ahb.hready !== 1'b0) begin errors++; $display("FAIL b2b_r_hready: got %0h want 0", ahb.hready); end
        tick();
        tick();
        checks++; if (ahb.hrdata !== 32'h12345678) begin errors++; $display("FAIL b2b_r_data: got %h want 12345678", ahb.hrdata); end
        checks++; if (sram_addr !== 8'h08) begin errors++; $display("FAIL b2b_r_last_addr: got %h want 08", sram_addr); end
        start_xfer(10'h010, 1'b0, 3'd2);
        tick();
        idle_bus();
        checks++; if (sram_addr !== 8'h04) begin errors++; $display("FAIL b2b_switch_addr: got %h want 04", sram_addr); end
        checks++; if (sram_cs_n !== 1'b0) begin errors++; $display("FAIL b2b_switch_cs_n: got %0h want 0", sram_cs_n); end
        checks++; if (ahb.hrdata !== 32'h12345678) begin errors++; $display("FAIL b2b_hold: got %h want 12345678", ahb.hrdata); end
        tick();
        tick();
        checks++; if (ahb.hrdata !== 32'hABADBEEF) begin errors++; $display("FAIL b2b_r2_data: got %h want abadbeef", ahb.hrdata); end
        tick();
    endtask

    task automatic test_reset_abort;
        pulses_before = we_pulses;
        start_xfer(10'h020, 1'b1, 3'd2);
        tick();
        ahb.hwdata = 32'hCAFEF00D;
        idle_bus();
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL abort_wait_we_n: got %0h want 1", sram_we_n); end
        #1 hreset = 1'b1;
        #1;
        checks++; if (ahb.hready !== 1'b1 || ahb.hresp !== 1'b0) begin
            errors++; $display("FAIL abort_bus: got ready=%0h resp=%0h want 1/0", ahb.hready, ahb.hresp);
        end
        checks++; if (sram_cs_n !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++; $display("FAIL abort_strobes: got cs_n=%0h we_n=%0h want 1/1", sram_cs_n, sram_we_n);
        end
        checks++; if (sram_addr !== 8'h0 || sram_be !== 4'h0) begin
            errors++; $display("FAIL abort_addr_be: got addr=%h be=%h want 0/0", sram_addr, sram_be);
        end
        checks++; if (ahb.hrdata !== 32'h0) begin errors++; $display("FAIL abort_hrdata: got %h want 0", ahb.hrdata); end
        tick();
        hreset = 1'b0;
        tick();
        checks++; if (we_pulses !== pulses_before) begin
            errors++; $display("FAIL abort_pulses: got %0d want %0d", we_pulses, pulses_before);
        end
        start_xfer(10'h020, 1'b0, 3'd2);
        tick();
        idle_bus();
        tick();
        tick();
        checks++; if (ahb.hrdata !== 32'h12345678) begin errors++; $display("FAIL abort_old_data: got %h want 12345678", ahb.hrdata); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word_write();
        test_read();
        test_byte_lanes();
        test_error();
        test_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
